bus_xfer_ctrl: RTL and testbench
================================

Name: bus_xfer_ctrl

Overview:
Sequencer that generates the eno/eni strobes for a bank of 32-bit enable/tristate registers sharing one 32-bit bus. It accepts a register-to-register move request (source index, destination index). It then steps a small FSM that enables the source onto the bus, strobes the destination's input enable, and reports completion. It sits directly upstream of the register bank, and its eno/eni vectors drive the register enables one bit per register.

Parameters:
NREG, 8, number of registers on the bus (2..16)
SELW, 3, width of register index fields; must satisfy 2^SELW >= NREG

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  move request present
req_ready  output  1  controller can accept a request (high only in IDLE)
req_src  input  SELW  source register index
req_dst  input  SELW  destination register index
bus  input  32  shared data bus, monitored only
eno  output  NREG  one-hot output enables, bit i drives register i onto the bus
eni  output  NREG  one-hot input enables, bit i makes register i load on the next clk edge
busy  output  1  transfer in progress (state != IDLE)
done  output  1  one-cycle pulse, transfer completed
err  output  1  one-cycle pulse, request rejected
last_data  output  32  bus value captured during the last completed transfer
xfer_count  output  16  count of completed transfers

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - eno=0, eni=0, busy=0, done=0, err=0, last_data=0, xfer_count=0, req_ready=1 after release.
  - Assertion mid-transfer releases the bus immediately, without waiting for a clock edge.
- All outputs are registered except req_ready and busy, which decode state.
- Handshake:
  - A request is accepted on the rising edge where req_valid && req_ready.
  - src/dst are latched internally at acceptance.
  - Request inputs are ignored outside IDLE.
- Validation at acceptance: if src == dst, src >= NREG, or dst >= NREG, go to ERR.
- FSM states: IDLE, DRIVE, LATCH, DONE, ERR.
  - IDLE: eno=0, eni=0. On accept go to DRIVE, or ERR if the request is invalid.
  - DRIVE (1 cycle): eno = 1<<src, eni = 0. This is the bus settle cycle. Next: LATCH.
  - LATCH (1 cycle): eno = 1<<src, eni = 1<<dst. On the closing edge of LATCH:
    - the destination register loads;
    - last_data <= bus;
    - xfer_count increments.
    Next: DONE.
  - DONE (1 cycle): eno=0, eni=0, done=1. Next: IDLE.
  - ERR (1 cycle): eno=0, eni=0, err=1. No count or last_data change. Next: IDLE.
- Timing for a valid request (accept edge = edge 0):
  - eno active in cycles 1-2.
  - eni active in cycle 2.
  - done high in cycle 3.
  - req_ready high again in cycle 4.
  - A valid transfer occupies 4 cycles from accept to the next possible accept.
  - An invalid request occupies 2 cycles.
- Invariants:
  - At most one eno bit and one eni bit are set in any cycle.
  - eni never asserts without the matching eno on the same cycle.
  - eni[src] is never set.
- xfer_count wraps from 16'hFFFF to 0.
- done and err are never high together.

Test Plan:
- Reset check: rst_n low -> eno=0, eni=0, busy=0, xfer_count=0, last_data=0, req_ready=1.
- Valid move: src=1, dst=4, bus driven 32'h0000FFFF while eno[1]=1.
  - Cycle 1: eno=8'h02, eni=0.
  - Cycle 2: eno=8'h02, eni=8'h10.
  - Cycle 3: done=1, enables 0.
  - After the transfer: last_data=32'h0000FFFF, xfer_count=1.
- Invalid requests:
  - src=3, dst=3 -> err pulse next cycle, eno/eni stay 0, xfer_count unchanged.
  - With NREG=6, dst=7 -> err pulse.
- Back-to-back: req_valid held high with two requests, 2->5 then 5->0.
  - Second accept occurs exactly 4 cycles after the first.
  - xfer_count=2.
  - eni sequence is 8'h20 then 8'h01.
  - Requests presented while busy are ignored until req_ready returns.
- Reset mid-transfer: rst_n low during LATCH -> eno/eni drop to 0 before the next clk edge, no done pulse, xfer_count=0. A new request after release completes normally.
- Wrap: preload via 65535 transfers (or force) -> next transfer gives xfer_count=0.

Source files
------------

// File: rtl/bus_xfer_ctrl.sv
// Register-to-register move sequencer for a shared 32-bit bus.
// Drives one-hot output/input enables for a bank of NREG registers.
module bus_xfer_ctrl #(
    parameter int NREG = 8,
    parameter int SELW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [SELW-1:0] req_src,
    input  logic [SELW-1:0] req_dst,
    input  logic [31:0]     bus,
    output logic [NREG-1:0] eno,
    output logic [NREG-1:0] eni,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [31:0]     last_data,
    output logic [15:0]     xfer_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRIVE = 3'd1,
        S_LATCH = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};
    localparam logic [31:0]     NREG_U   = 32'(NREG);

    state_t          state_q, state_d;
    logic [SELW-1:0] src_q, src_d;
    logic [SELW-1:0] dst_q, dst_d;
    logic [NREG-1:0] eno_q, eno_d;
    logic [NREG-1:0] eni_q, eni_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [31:0]     last_data_q, last_data_d;
    logic [15:0]     xfer_count_q, xfer_count_d;
    logic            req_ok_s;

    // A move is legal only between two distinct, existing registers.
    assign req_ok_s = (req_src != req_dst) &&
                      (32'(req_src) < NREG_U) &&
                      (32'(req_dst) < NREG_U);

    // Next-state and next-output decode; enables are computed one cycle early so they leave a flop.
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        eno_d        = {NREG{1'b0}};
        eni_d        = {NREG{1'b0}};
        done_d       = 1'b0;
        err_d        = 1'b0;
        last_data_d  = last_data_q;
        xfer_count_d = xfer_count_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    src_d = req_src;
                    dst_d = req_dst;
                    if (req_ok_s) begin
                        state_d = S_DRIVE;
                        eno_d   = ONE_HOT0 << req_src;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRIVE: begin
                state_d = S_LATCH;
                eno_d   = ONE_HOT0 << src_q;
                eni_d   = ONE_HOT0 << dst_q;
            end
            S_LATCH: begin
                // Closing edge of LATCH: destination loads and the bus value is recorded.
                state_d      = S_DONE;
                done_d       = 1'b1;
                last_data_d  = bus;
                xfer_count_d = xfer_count_q + 16'd1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; async reset drops the enables without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            src_q        <= {SELW{1'b0}};
            dst_q        <= {SELW{1'b0}};
            eno_q        <= {NREG{1'b0}};
            eni_q        <= {NREG{1'b0}};
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            last_data_q  <= 32'd0;
            xfer_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            eno_q        <= eno_d;
            eni_q        <= eni_d;
            done_q       <= done_d;
            err_q        <= err_d;
            last_data_q  <= last_data_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign eno        = eno_q;
    assign eni        = eni_q;
    assign done       = done_q;
    assign err        = err_q;
    assign last_data  = last_data_q;
    assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: a register bank on the bus plus an abstract move model
// (array copy, counter, last value) checked cycle by cycle against the DUT.
module tb_bus_xfer_ctrl;

    localparam int NREG = 6;
    localparam int SELW = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [SELW-1:0] req_src = '0;
    logic [SELW-1:0] req_dst = '0;
    logic [31:0]     bus;
    logic [NREG-1:0] eno, eni;
    logic            busy, done, err;
    logic [31:0]     last_data;
    logic [15:0]     xfer_count;

    bus_xfer_ctrl #(.NREG(NREG), .SELW(SELW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dst(req_dst), .bus(bus), .eno(eno), .eni(eni),
        .busy(busy), .done(done), .err(err), .last_data(last_data),
        .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_prev = 0;
    int acc_last = 0;

    // Environment: the register bank driven by the enables
    logic [31:0] bank [NREG];
    logic [31:0] seed [NREG];
    logic        preload = 1'b0;

    // Reference model: register contents, last value moved, completed count
    logic [31:0] mreg [NREG];
    logic [31:0] m_last = 32'd0;
    logic [15:0] m_count = 16'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < NREG; i++) bank[i] <= seed[i];
        end else begin
            for (int i = 0; i < NREG; i++) if (eni[i]) bank[i] <= bus;
        end
    end

    always_comb begin
        bus = 32'd0;
        for (int i = 0; i < NREG; i++) if (eno[i]) bus = bus | bank[i];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] oh(input int i);
        logic [31:0] one;
        one = 32'd1;
        return one << i;
    endfunction

    task automatic junk();
        req_src = SELW'($urandom_range(0, 7));
        req_dst = SELW'($urandom_range(0, 7));
    endtask

    task automatic xfer(input int s, input int d);
        bit ok;
        int n;
        ok = (s != d) && (s < NREG) && (d < NREG);
        n = 0;
        while (req_ready !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        chk("ready_before", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_src   = SELW'(s);
        req_dst   = SELW'(d);
        acc_prev  = acc_last;
        acc_last  = cyc;
        step();
        junk();
        if (ok) begin
            chk("c1_eno", 32'(eno), oh(s));
            chk("c1_eni", 32'(eni), 32'd0);
            chk("c1_busy", {30'd0, busy, req_ready}, 32'd2);
            step();
            junk();
            chk("c2_eno", 32'(eno), oh(s));
            chk("c2_eni", 32'(eni), oh(d));
            step();
            mreg[d] = mreg[s];
            m_last  = mreg[s];
            m_count = m_count + 16'd1;
            chk("c3_done_err", {30'd0, done, err}, 32'd2);
            chk("c3_enables", 32'({eno, eni}), 32'd0);
            chk("c3_last", last_data, m_last);
            chk("c3_count", 32'(xfer_count), 32'(m_count));
            chk("c3_bank_dst", bank[d], mreg[d]);
            step();
            chk("c4_ready_done", {30'd0, req_ready, done}, 32'd2);
        end else begin
            chk("e1_err_done", {30'd0, err, done}, 32'd2);
            chk("e1_enables", 32'({eno, eni}), 32'd0);
            chk("e1_count", 32'(xfer_count), 32'(m_count));
            step();
            chk("e2_ready_err", {30'd0, req_ready, err}, 32'd2);
            chk("e2_last", last_data, m_last);
        end
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NREG; i++) seed[i] = $urandom;
        seed[1] = 32'h0000FFFF;
        for (int i = 0; i < NREG; i++) mreg[i] = seed[i];
        preload = 1'b1;
        step();
        step();
        chk("rst_enables", 32'({eno, eni}), 32'd0);
        chk("rst_flags", {28'd0, busy, done, err, req_ready}, 32'd1);
        chk("rst_count", 32'(xfer_count), 32'd0);
        chk("rst_last", last_data, 32'd0);
        preload = 1'b0;
        rst_n = 1'b1;
        step();

        // Directed valid move
        xfer(1, 4);
        chk("move_last", last_data, 32'h0000FFFF);
        chk("move_count", 32'(xfer_count), 32'd1);

        // Invalid requests: same index, and indices past the last register
        xfer(3, 3);
        xfer(0, 7);
        xfer(6, 1);
        chk("inv_count", 32'(xfer_count), 32'd1);

        // Back-to-back with valid held high
        xfer(2, 5);
        xfer(5, 0);
        chk("b2b_gap", 32'(acc_last - acc_prev), 32'd4);
        chk("b2b_count", 32'(xfer_count), 32'd3);

        // Randomized moves, including out-of-range and equal indices
        for (int k = 0; k < 40; k++) xfer(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));

        // Reset asserted during LATCH
        req_valid = 1'b1;
        req_src   = SELW'(1);
        req_dst   = SELW'(4);
        step();
        req_valid = 1'b0;
        step();
        chk("mid_eni_before", 32'(eni), oh(4));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_enables_async", 32'({eno, eni}), 32'd0);
        step();
        chk("mid_no_done", 32'(done), 32'd0);
        chk("mid_count", 32'(xfer_count), 32'd0);
        m_count = 16'd0;
        m_last  = 32'd0;
        chk("mid_bank_dst", bank[4], mreg[4]);
        rst_n = 1'b1;
        step();
        xfer(1, 4);

        // Counter wrap
        force dut.xfer_count_q = 16'hFFFF;
        #1 release dut.xfer_count_q;
        m_count = 16'hFFFF;
        chk("wrap_pre", 32'(xfer_count), 32'h0000FFFF);
        xfer(0, 2);
        chk("wrap_zero", 32'(xfer_count), 32'd0);

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
